// File: rtl/chip8_mem_arbiter_pkg.sv
// Shared types, memory map and address mapping for the CHIP-8 BRAM port-A arbiter.
package chip8_mem_pkg;

  localparam int unsigned MEM_WIDTH      = 8;
  localparam int unsigned MEM_ADDR_WIDTH = 13;

  typedef enum logic [1:0] {
    ReqNone  = 2'd0,
    ReqProc  = 2'd1,
    ReqVideo = 2'd2,
    ReqFlash = 2'd3
  } requester_e;

  localparam logic [1:0] PROC_MEM_TYPE_RAM = 2'd0;
  localparam logic [1:0] PROC_MEM_TYPE_REG = 2'd1;
  localparam logic [1:0] PROC_MEM_TYPE_STK = 2'd2;

  localparam int unsigned RAM_DEPTH  = 4096;
  localparam int unsigned VRAM_DEPTH = 256;
  localparam int unsigned REG_DEPTH  = 23;
  localparam int unsigned STK_DEPTH  = 32;

  localparam int unsigned VRAM_BASE = 4096;
  localparam int unsigned REG_BASE  = 4352;
  localparam int unsigned STK_BASE  = 4375;

  typedef struct packed {
    logic                      we;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_WIDTH-1:0]      data;
  } stash_t;

  typedef struct packed {
    logic                      ok;
    logic [MEM_ADDR_WIDTH-1:0] addr;
  } map_t;

  function automatic map_t map_addr(requester_e src, logic [1:0] ptype, logic [15:0] addr);
    map_t        m;
    int unsigned a;
    a = 32'(addr);
    m = '0;
    unique case (src)
      ReqProc: begin
        unique case (ptype)
          PROC_MEM_TYPE_RAM: begin
            m.ok   = a < RAM_DEPTH;
            m.addr = MEM_ADDR_WIDTH'(a);
          end
          PROC_MEM_TYPE_REG: begin
            m.ok   = a < REG_DEPTH;
            m.addr = MEM_ADDR_WIDTH'(REG_BASE + a);
          end
          PROC_MEM_TYPE_STK: begin
            m.ok   = a < STK_DEPTH;
            m.addr = MEM_ADDR_WIDTH'(STK_BASE + a);
          end
          default: m = '0;
        endcase
      end
      ReqVideo: begin
        m.ok   = a < VRAM_DEPTH;
        m.addr = MEM_ADDR_WIDTH'(VRAM_BASE + a);
      end
      ReqFlash: begin
        m.ok   = a < RAM_DEPTH;
        m.addr = MEM_ADDR_WIDTH'(a);
      end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/chip8_mem_arbiter_if.sv
// Requester handshakes plus BRAM port-A signals of the memory arbiter.
interface chip8_mem_arbiter_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 13
);
  logic             proc_valid_in, proc_ready_out, proc_we_in;
  logic [1:0]       proc_type_in;
  logic [11:0]      proc_addr_in;
  logic [WIDTH-1:0] proc_data_in;

  logic             video_valid_in, video_ready_out, video_we_in;
  logic [15:0]      video_addr_in;
  logic [WIDTH-1:0] video_data_in;

  logic             flash_valid_in, flash_ready_out, flash_we_in;
  logic [11:0]      flash_addr_in;
  logic [WIDTH-1:0] flash_data_in;

  logic [ADDR_WIDTH-1:0] mem_addr_out;
  logic                  mem_we_out, mem_en_out;
  logic [WIDTH-1:0]      mem_data_out;

  logic proc_valid_out, video_valid_out, flash_valid_out, err_out;

  modport master (
    output proc_valid_in, proc_we_in, proc_type_in, proc_addr_in, proc_data_in,
    output video_valid_in, video_we_in, video_addr_in, video_data_in,
    output flash_valid_in, flash_we_in, flash_addr_in, flash_data_in,
    input  proc_ready_out, video_ready_out, flash_ready_out,
    input  mem_addr_out, mem_we_out, mem_en_out, mem_data_out,
    input  proc_valid_out, video_valid_out, flash_valid_out, err_out
  );

  modport slave (
    input  proc_valid_in, proc_we_in, proc_type_in, proc_addr_in, proc_data_in,
    input  video_valid_in, video_we_in, video_addr_in, video_data_in,
    input  flash_valid_in, flash_we_in, flash_addr_in, flash_data_in,
    output proc_ready_out, video_ready_out, flash_ready_out,
    output mem_addr_out, mem_we_out, mem_en_out, mem_data_out,
    output proc_valid_out, video_valid_out, flash_valid_out, err_out
  );
endinterface

// File: rtl/chip8_mem_arbiter_stash.sv
// One-entry request buffer: maps the local address at accept time and drops out-of-range requests.
module chip8_mem_stash
  import chip8_mem_pkg::*;
#(
  parameter requester_e Src = ReqProc
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic                 we,
  input  logic [1:0]           ptype,
  input  logic [15:0]          addr,
  input  logic [MEM_WIDTH-1:0] data,
  input  logic                 grant,
  output logic                 ready,
  output logic                 full,
  output stash_t               entry,
  output logic                 err
);
  logic   full_q, err_q, accept;
  stash_t entry_q;
  map_t   m;

  assign m      = map_addr(Src, ptype, addr);
  assign ready  = !full_q;
  assign accept = valid && ready;

  // A full stash blocks accept, so accept and grant never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      entry_q <= '0;
    end else begin
      err_q <= accept && !m.ok;
      if (accept && m.ok) begin
        full_q  <= 1'b1;
        entry_q <= '{we: we, addr: m.addr, data: data};
      end else if (grant) begin
        full_q <= 1'b0;
      end
    end
  end

  assign full  = full_q;
  assign entry = entry_q;
  assign err   = err_q;
endmodule

// File: rtl/pipeline.sv
// Generic fixed-depth delay line with asynchronous clear.
module pipeline #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data
);
  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign out_data = stage_q[DEPTH-1];
endmodule

// File: rtl/chip8_mem_arbiter.sv
// Round-robin arbiter for BRAM port A between processor, video and flash loader, with
// a tag delay line that routes each completion pulse back in step with BRAM read data.
module chip8_mem_arbiter
  import chip8_mem_pkg::*;
#(
  parameter int unsigned WIDTH        = MEM_WIDTH,
  parameter int unsigned ADDR_WIDTH   = MEM_ADDR_WIDTH,
  parameter int unsigned READ_LATENCY = 2
) (
  input logic                clk_in,
  input logic                rst_in,
  chip8_mem_arbiter_if.slave bus
);
  logic [2:0] full, grant, errs;
  stash_t     entry_p, entry_v, entry_f, win_entry;
  logic       found;
  logic [1:0] win_idx, rr_q, rr_d;
  requester_e issue_tag, issue_tag_q, done_tag;

  logic                  mem_en_q, mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [WIDTH-1:0]      mem_data_q;

  chip8_mem_stash #(.Src(ReqProc)) u_stash_proc (
    .clk(clk_in), .rst(rst_in), .valid(bus.proc_valid_in), .we(bus.proc_we_in),
    .ptype(bus.proc_type_in), .addr({4'b0, bus.proc_addr_in}), .data(bus.proc_data_in),
    .grant(grant[0]), .ready(bus.proc_ready_out), .full(full[0]), .entry(entry_p),
    .err(errs[0])
  );

  chip8_mem_stash #(.Src(ReqVideo)) u_stash_video (
    .clk(clk_in), .rst(rst_in), .valid(bus.video_valid_in), .we(bus.video_we_in),
    .ptype(2'b00), .addr(bus.video_addr_in), .data(bus.video_data_in),
    .grant(grant[1]), .ready(bus.video_ready_out), .full(full[1]), .entry(entry_v),
    .err(errs[1])
  );

  chip8_mem_stash #(.Src(ReqFlash)) u_stash_flash (
    .clk(clk_in), .rst(rst_in), .valid(bus.flash_valid_in), .we(bus.flash_we_in),
    .ptype(2'b00), .addr({4'b0, bus.flash_addr_in}), .data(bus.flash_data_in),
    .grant(grant[2]), .ready(bus.flash_ready_out), .full(full[2]), .entry(entry_f),
    .err(errs[2])
  );

  function automatic logic [1:0] rr_idx(logic [1:0] base, int unsigned off);
    return 2'((32'(base) + off) % 3);
  endfunction

  // Index 0/1/2 = PROC/VIDEO/FLASH; search starts at rr_q.
  always_comb begin
    found   = 1'b0;
    win_idx = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (!found && full[rr_idx(rr_q, i)]) begin
        found   = 1'b1;
        win_idx = rr_idx(rr_q, i);
      end
    end
    grant     = found ? (3'b001 << win_idx) : 3'b000;
    rr_d      = found ? rr_idx(win_idx, 1) : rr_q;
    issue_tag = found ? requester_e'(win_idx + 2'd1) : ReqNone;
    unique case (win_idx)
      2'd1:    win_entry = entry_v;
      2'd2:    win_entry = entry_f;
      default: win_entry = entry_p;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_q        <= 2'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      issue_tag_q <= ReqNone;
    end else begin
      rr_q        <= rr_d;
      mem_en_q    <= found;
      mem_we_q    <= found && win_entry.we;
      issue_tag_q <= issue_tag;
      if (found) begin
        mem_addr_q <= ADDR_WIDTH'(win_entry.addr);
        mem_data_q <= WIDTH'(win_entry.data);
      end
    end
  end

  // Tag of the issue cycle emerges READ_LATENCY cycles later, aligned with douta.
  pipeline #(.WIDTH(2), .DEPTH(READ_LATENCY)) u_tag_pipe (
    .clk(clk_in), .rst(rst_in), .in_data(issue_tag_q), .out_data(done_tag)
  );

  assign bus.mem_en_out      = mem_en_q;
  assign bus.mem_we_out      = mem_we_q;
  assign bus.mem_addr_out    = mem_addr_q;
  assign bus.mem_data_out    = mem_data_q;
  assign bus.proc_valid_out  = (done_tag == ReqProc);
  assign bus.video_valid_out = (done_tag == ReqVideo);
  assign bus.flash_valid_out = (done_tag == ReqFlash);
  assign bus.err_out         = |errs;
endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed bench for chip8_mem_arbiter: mapping, latency, round-robin, errors, reset.
module tb_chip8_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  chip8_mem_arbiter_if #(.WIDTH(8), .ADDR_WIDTH(13)) bus ();

  chip8_mem_arbiter #(.WIDTH(8), .ADDR_WIDTH(13), .READ_LATENCY(2)) dut (
    .clk_in(clk), .rst_in(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.proc_valid_in  = 0; bus.proc_we_in  = 0; bus.proc_type_in = 0;
    bus.proc_addr_in   = 0; bus.proc_data_in = 0;
    bus.video_valid_in = 0; bus.video_we_in = 0; bus.video_addr_in = 0;
    bus.video_data_in  = 0;
    bus.flash_valid_in = 0; bus.flash_we_in = 0; bus.flash_addr_in = 0;
    bus.flash_data_in  = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic req_proc(input logic we, input logic [1:0] t, input logic [11:0] a,
                          input logic [7:0] d);
    bus.proc_valid_in = 1; bus.proc_we_in = we; bus.proc_type_in = t;
    bus.proc_addr_in  = a; bus.proc_data_in = d;
  endtask

  task automatic req_video(input logic we, input logic [15:0] a, input logic [7:0] d);
    bus.video_valid_in = 1; bus.video_we_in = we; bus.video_addr_in = a;
    bus.video_data_in  = d;
  endtask

  task automatic req_flash(input logic we, input logic [11:0] a, input logic [7:0] d);
    bus.flash_valid_in = 1; bus.flash_we_in = we; bus.flash_addr_in = a;
    bus.flash_data_in  = d;
  endtask

  task automatic no_valids(input string tag);
    check({tag, "_pv"}, bus.proc_valid_out, 0);
    check({tag, "_vv"}, bus.video_valid_out, 0);
    check({tag, "_fv"}, bus.flash_valid_out, 0);
  endtask

  initial begin
    idle();
    // Reset state
    tick();
    check("rst_en", bus.mem_en_out, 0);
    check("rst_we", bus.mem_we_out, 0);
    check("rst_addr", bus.mem_addr_out, 0);
    check("rst_data", bus.mem_data_out, 0);
    check("rst_err", bus.err_out, 0);
    check("rst_rdy", {bus.proc_ready_out, bus.video_ready_out, bus.flash_ready_out}, 3'b111);
    no_valids("rst");
    rst = 1'b0;

    // Processor RAM read 0x200
    req_proc(0, 2'd0, 12'h200, 8'h00);
    tick();  // edge 0
    idle();
    check("rd_rdy0", bus.proc_ready_out, 0);
    check("rd_en0", bus.mem_en_out, 0);
    tick();  // edge 1
    check("rd_en1", bus.mem_en_out, 1);
    check("rd_we1", bus.mem_we_out, 0);
    check("rd_addr1", bus.mem_addr_out, 13'h200);
    check("rd_pv1", bus.proc_valid_out, 0);
    tick();  // edge 2
    check("rd_en2", bus.mem_en_out, 0);
    check("rd_rdy2", bus.proc_ready_out, 1);
    check("rd_pv2", bus.proc_valid_out, 0);
    tick();  // edge 3
    check("rd_pv3", bus.proc_valid_out, 1);
    check("rd_vv3", bus.video_valid_out, 0);
    tick();
    check("rd_pv4", bus.proc_valid_out, 0);

    // Processor REG write addr 15 -> 4367
    req_proc(1, 2'd1, 12'd15, 8'hAB);
    tick();
    idle();
    tick();
    check("reg_en", bus.mem_en_out, 1);
    check("reg_we", bus.mem_we_out, 1);
    check("reg_addr", bus.mem_addr_out, 4367);
    check("reg_data", bus.mem_data_out, 8'hAB);
    tick();
    check("reg_pv2", bus.proc_valid_out, 0);
    tick();
    check("reg_pv3", bus.proc_valid_out, 1);

    // Processor STK addr 31 -> 4406
    req_proc(0, 2'd2, 12'd31, 8'h00);
    tick();
    idle();
    tick();
    check("stk_addr", bus.mem_addr_out, 4406);
    check("stk_we", bus.mem_we_out, 0);
    tick();
    tick();

    // All three accepted together: PROC, VIDEO, FLASH on consecutive cycles
    do_reset();
    req_proc(0, 2'd0, 12'h123, 8'h00);
    req_video(0, 16'd10, 8'h00);
    req_flash(0, 12'h300, 8'h00);
    tick();  // edge 0
    idle();
    tick();
    check("tri_a1", bus.mem_addr_out, 13'h123);
    check("tri_en1", bus.mem_en_out, 1);
    tick();
    check("tri_a2", bus.mem_addr_out, 4106);
    check("tri_en2", bus.mem_en_out, 1);
    tick();
    check("tri_a3", bus.mem_addr_out, 13'h300);
    check("tri_pv3", bus.proc_valid_out, 1);
    check("tri_vv3", bus.video_valid_out, 0);
    tick();
    check("tri_en4", bus.mem_en_out, 0);
    check("tri_vv4", bus.video_valid_out, 1);
    check("tri_pv4", bus.proc_valid_out, 0);
    tick();
    check("tri_fv5", bus.flash_valid_out, 1);
    check("tri_vv5", bus.video_valid_out, 0);
    tick();
    no_valids("tri6");

    // Continuous proc + video: strict alternation, port busy every cycle
    do_reset();
    req_proc(1, 2'd0, 12'h010, 8'h5A);
    req_video(0, 16'd5, 8'h00);
    tick();  // edge 0
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("alt_en%0d", k), bus.mem_en_out, 1);
      check($sformatf("alt_a%0d", k), bus.mem_addr_out, (k % 2 == 1) ? 13'h010 : 13'd4101);
      check($sformatf("alt_we%0d", k), bus.mem_we_out, (k % 2 == 1) ? 1 : 0);
    end
    idle();
    repeat (4) tick();

    // Out-of-range requests: err pulse, no issue, no completion, ready stays high
    do_reset();
    req_video(0, 16'd256, 8'h00);
    tick();
    idle();
    check("oor_v_err", bus.err_out, 1);
    check("oor_v_rdy", bus.video_ready_out, 1);
    check("oor_v_en", bus.mem_en_out, 0);
    tick();
    check("oor_v_err1", bus.err_out, 0);
    check("oor_v_en1", bus.mem_en_out, 0);
    req_proc(0, 2'd1, 12'd23, 8'h00);
    tick();
    idle();
    check("oor_r_err", bus.err_out, 1);
    check("oor_r_rdy", bus.proc_ready_out, 1);
    no_valids("oor_r");
    tick();
    check("oor_r_err1", bus.err_out, 0);
    check("oor_r_en1", bus.mem_en_out, 0);
    req_proc(0, 2'd3, 12'd0, 8'h00);
    tick();
    idle();
    check("oor_t_err", bus.err_out, 1);
    tick();
    check("oor_t_err1", bus.err_out, 0);
    check("oor_t_en1", bus.mem_en_out, 0);
    no_valids("oor_t1");
    tick();
    no_valids("oor_t2");
    tick();
    no_valids("oor_t3");

    // Reset one cycle after a proc read issues
    do_reset();
    req_proc(0, 2'd0, 12'h050, 8'h00);
    tick();  // edge 0
    idle();
    tick();  // edge 1: issued
    check("mr_en", bus.mem_en_out, 1);
    rst = 1'b1;
    #1;
    check("mr_en_rst", bus.mem_en_out, 0);
    check("mr_rdy", {bus.proc_ready_out, bus.video_ready_out, bus.flash_ready_out}, 3'b111);
    tick();  // edge 2
    rst = 1'b0;
    tick();  // edge 3
    check("mr_pv3", bus.proc_valid_out, 0);
    tick();
    check("mr_pv4", bus.proc_valid_out, 0);
    req_proc(0, 2'd0, 12'h077, 8'h00);
    req_video(0, 16'd1, 8'h00);
    tick();
    idle();
    tick();
    check("mr_rr1", bus.mem_addr_out, 13'h077);
    tick();
    check("mr_rr2", bus.mem_addr_out, 4097);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
